// File: rtl/alu_mdu_if.sv
// Request/result bundle between a requester and the ALU/multiply-divide unit.
interface alu_mdu_if #(parameter int N = 32);
    logic         start;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic [N-1:0] alu_y;
    logic         zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;
    logic         done;

    modport master (output start, alu_a, alu_b, alu_control,
                    input  alu_y, zero, hi, lo, busy, done);
    modport slave  (input  start, alu_a, alu_b, alu_control,
                    output alu_y, zero, hi, lo, busy, done);
endinterface

// File: rtl/alu_mdu.sv
// ALU with single-cycle ops plus an iterative N-step multiplier/divider
// (shift-add multiply, restoring divide, sign fix-up in a final cycle).
module alu_mdu #(
    parameter int N = 32
) (
    input  logic      clk,
    input  logic      reset,
    alu_mdu_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N:0]   p_q, p_d;        // {upper N+1 bits, lower N bits} working register
    logic [N-1:0]   m_q, m_d;        // multiplicand / divisor magnitude
    logic [N-1:0]   a_q, a_d;        // raw dividend, kept for divide-by-zero
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;    // product/quotient sign
    logic           a_neg_q, a_neg_d; // remainder sign
    logic           divz_q, divz_d;
    logic [N-1:0]   alu_y_q, alu_y_d;
    logic           zero_q, zero_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           done_q, done_d;

    logic [N-1:0]   a, b, y1, a_mag, b_mag;
    logic           sop, is_md, is_dv;
    logic [N:0]     sum, top;
    logic [2*N:0]   sh;
    logic [2*N-1:0] prod;
    logic [N-1:0]   quo, rem;

    assign a = bus.alu_a;
    assign b = bus.alu_b;

    // Single-cycle result mux and operand decode for the iterative ops
    always_comb begin
        sop   = (bus.alu_control == 4'b1010) || (bus.alu_control == 4'b1100);
        is_md = (bus.alu_control >= 4'b1001) && (bus.alu_control <= 4'b1100);
        is_dv = (bus.alu_control == 4'b1011) || (bus.alu_control == 4'b1100);
        a_mag = (sop && a[N-1]) ? (~a + N'(1)) : a;
        b_mag = (sop && b[N-1]) ? (~b + N'(1)) : b;
        y1    = '0;
        case (bus.alu_control)
            4'b0000: y1 = a & b;
            4'b0001: y1 = a | b;
            4'b0010: y1 = a + b;
            4'b0011: y1 = a ^ b;
            4'b0100: y1 = a & ~b;
            4'b0101: y1 = {{(N-1){1'b0}}, a == b};
            4'b0110: y1 = a - b;
            4'b0111: y1 = {{(N-1){1'b0}}, a < b};
            4'b1000: y1 = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1101: y1 = hi_q;
            4'b1110: y1 = lo_q;
            default: y1 = '0;
        endcase
    end

    // Next-state: accept in IDLE, one iteration per CALC cycle, sign fix in FIX
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        a_d      = a_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        divz_d   = divz_q;
        alu_y_d  = alu_y_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        sum      = {1'b0, p_q[2*N-1:N]} + {1'b0, m_q};
        sh       = {p_q[2*N-1:0], 1'b0};
        top      = sh[2*N:N];
        prod     = neg_q ? (~p_q[2*N-1:0] + (2*N)'(1)) : p_q[2*N-1:0];
        quo      = neg_q ? (~p_q[N-1:0] + N'(1)) : p_q[N-1:0];
        rem      = a_neg_q ? (~p_q[2*N-1:N] + N'(1)) : p_q[2*N-1:N];
        case (state_q)
            IDLE: if (bus.start) begin
                if (is_md) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    is_div_d = is_dv;
                    neg_d    = sop && (a[N-1] ^ b[N-1]);
                    a_neg_d  = sop && a[N-1];
                    divz_d   = (b == '0);
                    a_d      = a;
                    p_d      = {{(N+1){1'b0}}, is_dv ? a_mag : b_mag};
                    m_d      = is_dv ? b_mag : a_mag;
                end else begin
                    alu_y_d = y1;
                    zero_d  = (y1 == '0);
                    done_d  = 1'b1;
                end
            end
            CALC: begin
                if (!is_div_q)
                    p_d = p_q[0] ? {1'b0, sum, p_q[N-1:1]} : {1'b0, p_q[2*N:1]};
                else if (top >= {1'b0, m_q})
                    p_d = {top - {1'b0, m_q}, sh[N-1:1], 1'b1};
                else
                    p_d = sh;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod;
                end else if (divz_q) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = quo;
                    hi_d = rem;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            a_q      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            divz_q   <= 1'b0;
            alu_y_q  <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            m_q      <= m_d;
            a_q      <= a_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            divz_q   <= divz_d;
            alu_y_q  <= alu_y_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.alu_y = alu_y_q;
    assign bus.zero  = zero_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu at N = 32.
module tb_alu_mdu;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   first_done, done_cnt, busy_cnt;

    alu_mdu_if #(.N(32)) bus_if();
    alu_mdu #(.N(32)) dut (.clk(clk), .reset(reset), .bus(bus_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, then watch max_cyc cycles (cycle 1 = first after accept).
    // Optionally inject an ignored ADD request at cycle inj and reset at cycle rst_at.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj, input int rst_at, input int max_cyc);
        @(negedge clk);
        bus_if.start       = 1'b1;
        bus_if.alu_control = op;
        bus_if.alu_a       = a;
        bus_if.alu_b       = b;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.alu_a = 32'hDEAD_BEEF;
        bus_if.alu_b = 32'h1234_5678;
        first_done = -1;
        done_cnt   = 0;
        busy_cnt   = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (bus_if.done) begin
                done_cnt++;
                if (first_done < 0) first_done = c;
            end
            if (bus_if.busy) busy_cnt++;
            if (c == inj) begin
                bus_if.start       = 1'b1;
                bus_if.alu_control = 4'b0010;
                bus_if.alu_a       = 32'd1;
                bus_if.alu_b       = 32'd1;
            end
            if (c == inj + 1) bus_if.start = 1'b0;
            if (c == rst_at) reset = 1'b1;
            if (c == rst_at + 1) reset = 1'b0;
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus_if.start       = 1'b0;
        bus_if.alu_a       = '0;
        bus_if.alu_b       = '0;
        bus_if.alu_control = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_y",    bus_if.alu_y, 0);
        chk("rst_zero", bus_if.zero,  1);
        chk("rst_hi",   bus_if.hi,    0);
        chk("rst_lo",   bus_if.lo,    0);
        chk("rst_busy", bus_if.busy,  0);
        chk("rst_done", bus_if.done,  0);
        reset = 1'b0;

        run(4'b0010, 32'hFFFF_FFFF, 32'd1, -5, -5, 3);
        chk("add_y",     bus_if.alu_y, 0);
        chk("add_zero",  bus_if.zero,  1);
        chk("add_dcyc",  first_done,   1);
        chk("add_dcnt",  done_cnt,     1);
        chk("add_busy",  busy_cnt,     0);

        run(4'b1000, 32'hFFFF_FFFF, 32'd1, -5, -5, 3);
        chk("slt_y",    bus_if.alu_y, 1);
        chk("slt_zero", bus_if.zero,  0);
        run(4'b0111, 32'hFFFF_FFFF, 32'd1, -5, -5, 3);
        chk("sltu_y",   bus_if.alu_y, 0);
        run(4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF, -5, -5, 3);
        chk("xor_y",    bus_if.alu_y, 32'hFF00_EDCB);
        run(4'b0100, 32'h0000_00FF, 32'h0000_000F, -5, -5, 3);
        chk("andn_y",   bus_if.alu_y, 32'h0000_00F0);
        run(4'b0101, 32'd7, 32'd7, -5, -5, 3);
        chk("eq_y",     bus_if.alu_y, 1);
        run(4'b1111, 32'd5, 32'd9, -5, -5, 3);
        chk("zop_y",    bus_if.alu_y, 0);
        chk("zop_zero", bus_if.zero,  1);
        run(4'b0110, 32'd5, 32'd7, -5, -5, 3);
        chk("sub_y",    bus_if.alu_y, 32'hFFFF_FFFE);

        run(4'b1010, 32'hFFFF_FFFD, 32'd7, -5, -5, 36);
        chk("mult_hi",   bus_if.hi,    32'hFFFF_FFFF);
        chk("mult_lo",   bus_if.lo,    32'hFFFF_FFEB);
        chk("mult_dcyc", first_done,   34);
        chk("mult_dcnt", done_cnt,     1);
        chk("mult_busy", busy_cnt,     33);
        chk("mult_y",    bus_if.alu_y, 32'hFFFF_FFFE);

        run(4'b1100, 32'hFFFF_FFF9, 32'd2, -5, -5, 36);
        chk("div_lo",   bus_if.lo, 32'hFFFF_FFFD);
        chk("div_hi",   bus_if.hi, 32'hFFFF_FFFF);
        run(4'b1101, 32'd0, 32'd0, -5, -5, 3);
        chk("mfhi_y",   bus_if.alu_y, 32'hFFFF_FFFF);

        run(4'b1011, 32'd5, 32'd0, -5, -5, 36);
        chk("divz_lo",  bus_if.lo, 32'hFFFF_FFFF);
        chk("divz_hi",  bus_if.hi, 32'd5);
        run(4'b1110, 32'd0, 32'd0, -5, -5, 3);
        chk("mflo_y",   bus_if.alu_y, 32'hFFFF_FFFF);

        run(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, -5, -5, 36);
        chk("divov_lo", bus_if.lo, 32'h8000_0000);
        chk("divov_hi", bus_if.hi, 32'd0);
        run(4'b1011, 32'd100, 32'd7, -5, -5, 36);
        chk("divu_lo",  bus_if.lo, 32'd14);
        chk("divu_hi",  bus_if.hi, 32'd2);

        run(4'b0010, 32'd3, 32'd4, -5, -5, 3);
        chk("add2_y",   bus_if.alu_y, 32'd7);
        run(4'b1001, 32'h0001_0000, 32'h0001_0000, 10, -5, 36);
        chk("inj_hi",   bus_if.hi,    32'd1);
        chk("inj_lo",   bus_if.lo,    32'd0);
        chk("inj_dcnt", done_cnt,     1);
        chk("inj_dcyc", first_done,   34);
        chk("inj_y",    bus_if.alu_y, 32'd7);

        run(4'b1011, 32'd1000, 32'd3, -5, 15, 40);
        chk("abort_dcnt", done_cnt,     0);
        chk("abort_busy", bus_if.busy,  0);
        chk("abort_bcnt", busy_cnt,     15);
        chk("abort_hi",   bus_if.hi,    0);
        chk("abort_lo",   bus_if.lo,    0);
        run(4'b1110, 32'd0, 32'd0, -5, -5, 3);
        chk("abort_mflo", bus_if.alu_y, 0);
        chk("abort_zero", bus_if.zero,  1);
        chk("abort_done", done_cnt,     1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
